// File: rtl/fir_pkg.sv
// Shared types, default widths and the saturating narrow helper for the FIR MAC core.
// sat_narrow is only referenced when FIR_SATURATE_EN is defined.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam int NTAPS_DEF  = 8;

  // Clamp an already-shifted accumulator value into the signed range of data_w bits.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] acc,
                                                    input int data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/fir_mac_core_if.sv
// Sample-in / result-out valid-ready handshake bundle for fir_mac_core.
interface fir_mac_core_if #(
  parameter int DATA_W = 16
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/fir_coef_bank.sv
// NTAPS x COEF_W coefficient register file: one synchronous write port,
// one asynchronous read port driven by the tap counter, cleared on reset.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int NTAPS  = NTAPS_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(NTAPS)-1:0]   waddr,
  input  logic signed [COEF_W-1:0]   wdata,
  input  logic [$clog2(NTAPS)-1:0]   raddr,
  output logic signed [COEF_W-1:0]   rdata
);

  logic signed [COEF_W-1:0] c [NTAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) c[i] <= '0;
    end else if (we) begin
      c[waddr] <= wdata;
    end
  end

  assign rdata = c[raddr];

endmodule

// File: rtl/fir_mac_core.sv
// Time-multiplexed FIR: one MAC per clock over the delay line, result via valid/ready.
// Define FIR_SATURATE_EN to clamp the output instead of wrapping it.
module fir_mac_core
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int NTAPS  = NTAPS_DEF
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     coef_err,
  output logic                     busy,
  fir_mac_core_if.slave            bus
);

  localparam int TAP_W = $clog2(NTAPS);
  localparam int ACC_W = DATA_W + COEF_W + TAP_W;

  state_t                          state;
  logic signed [DATA_W-1:0]        x [NTAPS];
  logic signed [ACC_W-1:0]         acc;
  logic signed [ACC_W-1:0]         acc_next;
  logic [TAP_W-1:0]                tap;
  logic signed [COEF_W-1:0]        coef_rd;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic [DATA_W-1:0]               result;
  logic [DATA_W-1:0]               m_data_q;
  logic                            coef_err_q;

  fir_coef_bank #(
    .NTAPS  (NTAPS),
    .COEF_W (COEF_W)
  ) u_coef_bank (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .we    (coef_we && (state == IDLE)),
    .waddr (coef_addr),
    .wdata (coef_wdata),
    .raddr (tap),
    .rdata (coef_rd)
  );

  assign prod     = x[tap] * coef_rd;
  assign acc_next = acc + ACC_W'(prod);

`ifdef FIR_SATURATE_EN
  assign result = DATA_W'(sat_narrow(64'(acc_next >>> (COEF_W - 1)), DATA_W));
`else
  assign result = DATA_W'(acc_next >>> (COEF_W - 1));
`endif

  // The last tap's sum is narrowed straight into m_data so it is stable for all of OUT.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= IDLE;
      acc      <= '0;
      tap      <= '0;
      m_data_q <= '0;
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.s_valid) begin
            x[0] <= bus.s_data;
            for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            acc   <= '0;
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          tap <= tap + 1'b1;
          if (tap == TAP_W'(NTAPS - 1)) begin
            m_data_q <= result;
            state    <= OUT;
          end
        end
        OUT: begin
          if (bus.m_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) coef_err_q <= 1'b0;
    else          coef_err_q <= coef_we && (state != IDLE);
  end

  assign bus.s_ready = (state == IDLE);
  assign bus.m_valid = (state == OUT);
  assign bus.m_data  = m_data_q;
  assign busy        = (state != IDLE);
  assign coef_err    = coef_err_q;

endmodule

// File: tb/tb_fir_mac_core.sv
// Self-checking bench for fir_mac_core: directed scenarios plus random traffic
// compared against an arithmetic FIR model (honours FIR_SATURATE_EN).
module tb_fir_mac_core;

  localparam int NTAPS = 8;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        coef_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int mx [NTAPS];
  int mc [NTAPS];

  always #5 ACLK = ~ACLK;

  fir_mac_core_if #(.DATA_W(16)) bus ();

  fir_mac_core #(
    .DATA_W (16),
    .COEF_W (16),
    .NTAPS  (NTAPS)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err),
    .busy       (busy),
    .bus        (bus)
  );

  // Reference: dot product of delay line and coefficients, floor-shift by 15, then narrow.
  function automatic logic [15:0] model_out();
    longint sum;
    logic [15:0] r;
    sum = 0;
    for (int k = 0; k < NTAPS; k++) sum += longint'(mx[k]) * longint'(mc[k]);
    sum = sum >>> 15;
`ifdef FIR_SATURATE_EN
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
`endif
    r = sum[15:0];
    return r;
  endfunction

  task automatic model_push(input logic [15:0] d);
    for (int k = NTAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = int'($signed(d));
  endtask

  task automatic model_clear();
    for (int k = 0; k < NTAPS; k++) begin
      mx[k] = 0;
      mc[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic write_coef(input int addr, input int val);
    logic [15:0] v;
    v = val[15:0];
    coef_we    = 1'b1;
    coef_addr  = addr[2:0];
    coef_wdata = v;
    tick();
    coef_we = 1'b0;
    mc[addr] = int'($signed(v));
  endtask

  task automatic load_random_coefs();
    for (int k = 0; k < NTAPS; k++) write_coef(k, int'($urandom_range(0, 65535)));
  endtask

  task automatic wait_m_valid(input string name, output int lat);
    lat = 1;
    while (bus.m_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != NTAPS + 1) begin
      failures++;
      $display("[TB] FAIL %s latency: got %0d cycles, want %0d", name, lat, NTAPS + 1);
    end
  endtask

  // Send one sample, check latency and result, optionally stall the consumer.
  task automatic send(input string name, input logic [15:0] d, input int stall,
                      output logic [15:0] res);
    int lat;
    logic [15:0] exp;
    lat = 0;
    while (bus.s_ready !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    bus.m_ready = (stall == 0);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    tick();
    bus.s_valid = 1'b0;
    model_push(d);
    exp = model_out();
    wait_m_valid(name, lat);
    checks++;
    if (bus.m_data !== exp) begin
      failures++;
      $display("[TB] FAIL %s m_data: got %h, want %h", name, bus.m_data, exp);
    end
    res = bus.m_data;
    for (int i = 0; i < stall; i++) begin
      tick();
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp || bus.s_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s stall: m_valid=%b m_data=%h s_ready=%b, want 1 %h 0",
                 name, bus.m_valid, bus.m_data, bus.s_ready, exp);
      end
    end
    bus.m_ready = 1'b1;
    tick();
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s handshake: s_ready=%b m_valid=%b, want 1 0",
               name, bus.s_ready, bus.m_valid);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.m_data !== 16'h0 ||
        busy !== 1'b0 || coef_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s: s_ready=%b m_valid=%b m_data=%h busy=%b coef_err=%b, want 1 0 0000 0 0",
               name, bus.s_ready, bus.m_valid, bus.m_data, busy, coef_err);
    end
  endtask

  task automatic test_reset();
    logic [15:0] res;
    int seen;
    ARESETN     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_wdata  = '0;
    model_clear();
    repeat (3) tick();
    check_reset_outputs("reset_initial");
    ARESETN = 1'b1;
    tick();
    load_random_coefs();
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h1234;
    tick();
    bus.s_valid = 1'b0;
    repeat (3) tick();
    #2 ARESETN = 1'b0;
    #1 check_reset_outputs("reset_mid_mac");
    model_clear();
    tick();
    ARESETN = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.m_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("[TB] FAIL reset_no_m_valid: got %0d valid cycles, want 0", seen);
    end
    for (int i = 0; i < 3; i++) begin
      send("reset_zero_coef", 16'($urandom_range(0, 65535)), 0, res);
      checks++;
      if (res !== 16'h0) begin
        failures++;
        $display("[TB] FAIL reset_coef_cleared: got %h, want 0000", res);
      end
    end
  endtask

  task automatic test_impulse();
    logic [15:0] res;
    logic [15:0] want;
    for (int k = 0; k < NTAPS; k++) write_coef(k, 4096 * k);
    for (int i = 0; i < NTAPS; i++) send("impulse_flush", 16'h0, 0, res);
    for (int n = 0; n <= NTAPS; n++) begin
      send("impulse", (n == 0) ? 16'd8 : 16'd0, 0, res);
      want = (n < NTAPS) ? 16'(n) : 16'd0;
      checks++;
      if (res !== want) begin
        failures++;
        $display("[TB] FAIL impulse_seq[%0d]: got %h, want %h", n, res, want);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] res;
    logic [15:0] want;
    for (int k = 0; k < NTAPS; k++) write_coef(k, 32767);
    for (int i = 0; i < NTAPS; i++) send("saturation", 16'h7FFF, 0, res);
`ifdef FIR_SATURATE_EN
    want = 16'h7FFF;
`else
    want = 16'hFFF0;
`endif
    checks++;
    if (res !== want) begin
      failures++;
      $display("[TB] FAIL saturation_last: got %h, want %h", res, want);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] res;
    logic [15:0] exp;
    int lat;
    load_random_coefs();
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'($urandom_range(0, 65535));
    model_push(bus.s_data);
    exp = model_out();
    tick();
    bus.s_valid = 1'b0;
    wait_m_valid("backpressure", lat);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h5A5A;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.m_data !== exp || bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL backpressure_hold[%0d]: m_data=%h s_ready=%b m_valid=%b, want %h 0 1",
                 i, bus.m_data, bus.s_ready, bus.m_valid, exp);
      end
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL backpressure_release: m_valid=%b s_ready=%b, want 0 1",
               bus.m_valid, bus.s_ready);
    end
    send("backpressure_next", 16'($urandom_range(0, 65535)), 0, res);
  endtask

  task automatic test_busy_coef_write();
    logic [15:0] res;
    logic [15:0] exp;
    int lat;
    load_random_coefs();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'($urandom_range(0, 65535));
    model_push(bus.s_data);
    exp = model_out();
    tick();
    bus.s_valid = 1'b0;
    tick();
    coef_we    = 1'b1;
    coef_addr  = 3'd0;
    coef_wdata = 16'd16384;
    tick();
    coef_we = 1'b0;
    checks++;
    if (coef_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_coef_err_pulse: got %b, want 1", coef_err);
    end
    tick();
    checks++;
    if (coef_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_coef_err_single: got %b, want 0", coef_err);
    end
    lat = 0;
    while (bus.m_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== exp) begin
      failures++;
      $display("[TB] FAIL busy_coef_current: m_valid=%b m_data=%h, want 1 %h",
               bus.m_valid, bus.m_data, exp);
    end
    tick();
    send("busy_coef_next", 16'($urandom_range(0, 65535)), 0, res);
  endtask

  task automatic test_same_cycle_write();
    logic [15:0] exp;
    int lat;
    for (int k = 0; k < NTAPS; k++) write_coef(k, 0);
    coef_we     = 1'b1;
    coef_addr   = 3'd0;
    coef_wdata  = 16'd16384;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'd1000;
    tick();
    coef_we     = 1'b0;
    bus.s_valid = 1'b0;
    mc[0] = 16384;
    model_push(16'd1000);
    exp = model_out();
    wait_m_valid("same_cycle", lat);
    checks++;
    if (bus.m_data !== 16'd500 || bus.m_data !== exp) begin
      failures++;
      $display("[TB] FAIL same_cycle_result: got %h, want 01f4 (model %h)", bus.m_data, exp);
    end
    checks++;
    if (coef_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL same_cycle_no_err: got %b, want 0", coef_err);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] res;
    for (int round = 0; round < 3; round++) begin
      load_random_coefs();
      for (int i = 0; i < 12; i++)
        send("random", 16'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), res);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_busy_coef_write();
    test_same_cycle_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
